// File: rtl/mem_stage_if.sv
// mem_stage_if: word-wide data memory port using a req/gnt/rvalid protocol.
// master = load/store unit, slave = data memory.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_gnt,
    input  dmem_rvalid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_gnt,
    output dmem_rvalid,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: RV32 memory stage between ex_m and m_wb.
// ALU results pass through; loads/stores stall upstream while in flight.
module mem_stage #(
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] rd_in,
  input  logic [31:0] store_data_in,
  input  logic        writeback_en_in,
  output logic        stall,
  output logic        valid_out,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] rd_out,
  output logic        writeback_en_out,
  output logic        fault_out,
  mem_stage_if.master dmem
);

  localparam int CW = $clog2(DMEM_TIMEOUT + 2);
  localparam logic [CW-1:0] TLAST =
    CW'(DMEM_TIMEOUT > 0 ? DMEM_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  typedef struct packed {
    logic        load;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [4:0]  rd_addr;
    logic        wb_en;
  } op_t;

  state_t        state;
  state_t        state_nxt;
  op_t           op;
  op_t           op_in;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          timed_out;

  logic          memop;
  logic          illegal;
  logic          misaligned;
  logic [1:0]    off;
  logic          latch;
  logic          stall_c;

  logic          valid_nxt;
  logic [4:0]    rd_addr_nxt;
  logic [31:0]   rd_nxt;
  logic          wb_nxt;
  logic          fault_nxt;

  logic [7:0]    lbyte;
  logic [15:0]   lhalf;
  logic [31:0]   ldata;

  assign off   = rd_in[1:0];
  assign memop = valid_in & (mem_read_in | mem_write_in);

  assign illegal =
    (mem_read_in & mem_write_in) |
    (funct3_in == 3'b011) |
    (funct3_in[2:1] == 2'b11) |
    (mem_write_in & funct3_in[2]);

  assign misaligned =
    ((funct3_in[1:0] == 2'b01) & off[0]) |
    ((funct3_in[1:0] == 2'b10) & (off != 2'b00));

  assign busy      = (state == REQ) | (state == RESP);
  assign timed_out = (DMEM_TIMEOUT != 0) && (cnt >= TLAST);

  // Store data is lane-replicated so the byte enables alone pick the lanes.
  always_comb begin
    op_in         = '0;
    op_in.load    = mem_read_in;
    op_in.funct3  = funct3_in;
    op_in.addr    = rd_in;
    op_in.rd_addr = rd_addr_in;
    op_in.wb_en   = writeback_en_in;
    unique case (funct3_in[1:0])
      2'b00: begin
        op_in.wdata = {4{store_data_in[7:0]}};
        op_in.be    = 4'b0001 << off;
      end
      2'b01: begin
        op_in.wdata = {2{store_data_in[15:0]}};
        op_in.be    = 4'b0011 << off;
      end
      default: begin
        op_in.wdata = store_data_in;
        op_in.be    = 4'b1111;
      end
    endcase
    if (mem_read_in) begin
      op_in.be = 4'b1111;
    end
  end

  always_comb begin
    lbyte = dmem.dmem_rdata[{op.addr[1:0], 3'b000} +: 8];
    lhalf = dmem.dmem_rdata[{op.addr[1], 4'b0000} +: 16];
    unique case (op.funct3)
      3'b000:  ldata = {{24{lbyte[7]}}, lbyte};
      3'b100:  ldata = {24'b0, lbyte};
      3'b001:  ldata = {{16{lhalf[15]}}, lhalf};
      3'b101:  ldata = {16'b0, lhalf};
      default: ldata = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    stall_c     = 1'b0;
    latch       = 1'b0;
    valid_nxt   = 1'b0;
    rd_addr_nxt = rd_addr_out;
    rd_nxt      = rd_out;
    wb_nxt      = 1'b0;
    fault_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (memop && !(illegal || misaligned)) begin
          state_nxt = REQ;
          stall_c   = 1'b1;
          latch     = 1'b1;
        end else if (memop) begin
          valid_nxt   = 1'b1;
          rd_addr_nxt = rd_addr_in;
          rd_nxt      = rd_in;
          fault_nxt   = 1'b1;
        end else begin
          valid_nxt   = valid_in;
          rd_addr_nxt = rd_addr_in;
          rd_nxt      = rd_in;
          wb_nxt      = writeback_en_in;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (dmem.dmem_gnt) begin
          state_nxt = op.load ? RESP : DONE;
          if (!op.load) begin
            valid_nxt   = 1'b1;
            rd_addr_nxt = op.rd_addr;
            rd_nxt      = op.addr;
          end
        end else if (timed_out) begin
          state_nxt   = DONE;
          valid_nxt   = 1'b1;
          rd_addr_nxt = op.rd_addr;
          rd_nxt      = op.addr;
          fault_nxt   = 1'b1;
        end
      end
      RESP: begin
        stall_c = 1'b1;
        if (dmem.dmem_rvalid) begin
          state_nxt   = DONE;
          valid_nxt   = 1'b1;
          rd_addr_nxt = op.rd_addr;
          rd_nxt      = ldata;
          wb_nxt      = op.wb_en;
        end else if (timed_out) begin
          state_nxt   = DONE;
          valid_nxt   = 1'b1;
          rd_addr_nxt = op.rd_addr;
          rd_nxt      = op.addr;
          fault_nxt   = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset must release upstream immediately, even with a memop presented.
  assign stall = stall_c & ~rst;

  assign dmem.dmem_req   = (state == REQ);
  assign dmem.dmem_we    = (state == REQ) & ~op.load;
  assign dmem.dmem_addr  = {op.addr[31:2], 2'b00};
  assign dmem.dmem_be    = op.be;
  assign dmem.dmem_wdata = op.wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      op               <= '0;
      valid_out        <= 1'b0;
      rd_addr_out      <= '0;
      rd_out           <= '0;
      writeback_en_out <= 1'b0;
      fault_out        <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= busy ? cnt + CW'(1) : '0;
      if (latch) begin
        op <= op_in;
      end
      valid_out        <= valid_nxt;
      rd_addr_out      <= rd_addr_nxt;
      rd_out           <= rd_nxt;
      writeback_en_out <= wb_nxt;
      fault_out        <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a
// behavioural model of the load/store rules.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] rd_in;
  logic [31:0] store_data_in;
  logic        writeback_en_in;

  logic        stall;
  logic        valid_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_out;
  logic        writeback_en_out;
  logic        fault_out;

  logic        t_stall;
  logic        t_valid;
  logic [4:0]  t_rd_addr;
  logic [31:0] t_rd;
  logic        t_wb;
  logic        t_fault;

  int nvec = 0;
  int nerr = 0;

  mem_stage_if m_if ();
  mem_stage_if t_if ();

  assign t_if.dmem_gnt    = 1'b0;
  assign t_if.dmem_rvalid = 1'b0;
  assign t_if.dmem_rdata  = 32'h0;

  always #5 clk = ~clk;

  mem_stage u_dut (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .funct3_in        (funct3_in),
    .rd_addr_in       (rd_addr_in),
    .rd_in            (rd_in),
    .store_data_in    (store_data_in),
    .writeback_en_in  (writeback_en_in),
    .stall            (stall),
    .valid_out        (valid_out),
    .rd_addr_out      (rd_addr_out),
    .rd_out           (rd_out),
    .writeback_en_out (writeback_en_out),
    .fault_out        (fault_out),
    .dmem             (m_if)
  );

  mem_stage #(.DMEM_TIMEOUT(4)) u_tmo (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .funct3_in        (funct3_in),
    .rd_addr_in       (rd_addr_in),
    .rd_in            (rd_in),
    .store_data_in    (store_data_in),
    .writeback_en_in  (writeback_en_in),
    .stall            (t_stall),
    .valid_out        (t_valid),
    .rd_addr_out      (t_rd_addr),
    .rd_out           (t_rd),
    .writeback_en_out (t_wb),
    .fault_out        (t_fault),
    .dmem             (t_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_fault(input logic r, input logic w,
                                   input logic [2:0] f3,
                                   input logic [31:0] a);
    if (r && w) return 1'b1;
    if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
    if (w && f3[2]) return 1'b1;
    return (int'(a[1:0]) % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic r, input logic [2:0] f3,
                                      input logic [31:0] a);
    logic [3:0] be;
    int o;
    int s;
    if (r) return 4'hF;
    o  = int'(a[1:0]);
    s  = size_of(f3);
    be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= o) && (i < o + s);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                          input logic [31:0] d);
    logic [31:0] x;
    int s;
    s = size_of(f3);
    for (int i = 0; i < 4; i++) x[8*i +: 8] = d[8*(i % s) +: 8];
    return x;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] rdat);
    longint unsigned v;
    int bits;
    if (size_of(f3) == 4) return rdat;
    bits = 8 * size_of(f3);
    v = {32'h0, rdat};
    v = (v >> (8 * int'(a[1:0]))) % (64'd1 << bits);
    if (!f3[2] && v >= (64'd1 << (bits - 1)))
      v = v + (64'h1_0000_0000 - (64'd1 << bits));
    return v[31:0];
  endfunction

  // Presents one instruction in IDLE and walks it to completion.
  task automatic issue(input logic v, input logic r, input logic w,
                       input logic [2:0] f3, input logic [4:0] ra,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic wb, input int gd, input int rdl,
                       input logic [31:0] rdat);
    logic memop;
    logic flt;
    memop = v && (r || w);
    flt   = memop && m_fault(r, w, f3, a);
    valid_in        = v;
    mem_read_in     = r;
    mem_write_in    = w;
    funct3_in       = f3;
    rd_addr_in      = ra;
    rd_in           = a;
    store_data_in   = sd;
    writeback_en_in = wb;
    #1;
    if (!memop || flt) begin
      chk("pass_stall", stall, 0);
      chk("pass_req", m_if.dmem_req, 0);
      tick();
      chk("pass_valid", valid_out, v);
      chk("pass_fault", fault_out, flt);
      if (v) begin
        chk("pass_rd_addr", rd_addr_out, ra);
        chk("pass_wb", writeback_en_out, flt ? 1'b0 : wb);
        if (!flt) chk("pass_rd", rd_out, a);
      end
      return;
    end
    chk("idle_stall", stall, 1);
    tick();
    for (int i = 0; i <= gd; i++) begin
      m_if.dmem_gnt = (i == gd);
      #1;
      chk("req_req", m_if.dmem_req, 1);
      chk("req_we", m_if.dmem_we, !r);
      chk("req_addr", m_if.dmem_addr, a & 32'hFFFF_FFFC);
      chk("req_be", m_if.dmem_be, m_be(r, f3, a));
      if (!r) chk("req_wdata", m_if.dmem_wdata, m_wdata(f3, sd));
      chk("req_stall", stall, 1);
      chk("req_valid", valid_out, 0);
      tick();
    end
    m_if.dmem_gnt = 1'b0;
    if (r) begin
      for (int i = 0; i <= rdl; i++) begin
        m_if.dmem_rvalid = (i == rdl);
        m_if.dmem_rdata  = (i == rdl) ? rdat : $urandom;
        #1;
        chk("resp_stall", stall, 1);
        chk("resp_req", m_if.dmem_req, 0);
        chk("resp_valid", valid_out, 0);
        tick();
      end
      m_if.dmem_rvalid = 1'b0;
    end
    chk("done_valid", valid_out, 1);
    chk("done_fault", fault_out, 0);
    chk("done_stall", stall, 0);
    chk("done_rd_addr", rd_addr_out, ra);
    chk("done_wb", writeback_en_out, r ? wb : 1'b0);
    chk("done_rd", rd_out, r ? m_load(f3, a, rdat) : a);
    tick();
    valid_in     = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    #1;
    chk("bubble_valid", valid_out, 0);
    chk("bubble_req", m_if.dmem_req, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic        v;
  logic        r;
  logic        w;
  logic [2:0]  f3;
  logic [31:0] a;
  int          k;
  int          t;

  initial begin
    rst             = 1'b1;
    valid_in        = 1'b0;
    mem_read_in     = 1'b0;
    mem_write_in    = 1'b0;
    funct3_in       = 3'b0;
    rd_addr_in      = 5'd0;
    rd_in           = 32'h0;
    store_data_in   = 32'h0;
    writeback_en_in = 1'b0;
    m_if.dmem_gnt    = 1'b0;
    m_if.dmem_rvalid = 1'b0;
    m_if.dmem_rdata  = 32'h0;
    repeat (3) tick();
    chk("rst_valid", valid_out, 0);
    chk("rst_rd", rd_out, 0);
    chk("rst_rd_addr", rd_addr_out, 0);
    chk("rst_wb", writeback_en_out, 0);
    chk("rst_fault", fault_out, 0);
    chk("rst_stall", stall, 0);
    chk("rst_req", m_if.dmem_req, 0);
    rst = 1'b0;
    tick();

    issue(1, 0, 0, 3'b000, 5'd5, 32'h11, 32'h0, 1, 0, 0, 32'h0);
    issue(1, 0, 0, 3'b000, 5'd6, 32'h22, 32'h0, 1, 0, 0, 32'h0);
    issue(1, 0, 0, 3'b000, 5'd0, 32'h33, 32'h0, 1, 0, 0, 32'h0);
    valid_in = 1'b0;
    tick();
    chk("alu_idle_valid", valid_out, 0);

    issue(1, 1, 0, 3'b000, 5'd8, 32'h103, 32'h0, 1, 0, 0, 32'h80FF_1234);
    issue(1, 0, 1, 3'b001, 5'd9, 32'h202, 32'hDEAD_BEEF, 1, 3, 0, 32'h0);
    issue(1, 1, 0, 3'b010, 5'd7, 32'h101, 32'h0, 1, 0, 0, 32'h0);
    valid_in = 1'b0;
    tick();
    chk("fault_pulse_end", fault_out, 0);
    issue(1, 1, 0, 3'b101, 5'd10, 32'h302, 32'h0, 1, 1, 2, 32'h8765_4321);
    issue(1, 1, 1, 3'b010, 5'd11, 32'h300, 32'h0, 1, 0, 0, 32'h0);
    issue(1, 0, 1, 3'b100, 5'd12, 32'h300, 32'h0, 1, 0, 0, 32'h0);

    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 9);
      v = ($urandom_range(0, 7) != 0);
      r = ((k >= 3) && (k < 6)) || (k == 9);
      w = (k >= 6);
      if ($urandom_range(0, 7) == 0) begin
        f3 = 3'($urandom_range(0, 7));
      end else if (w) begin
        f3 = 3'($urandom_range(0, 2));
      end else begin
        t  = $urandom_range(0, 4);
        f3 = (t < 3) ? 3'(t) : 3'(t + 1);
      end
      a = $urandom;
      if ($urandom_range(0, 3) != 0)
        a = a & ~(32'(size_of(f3)) - 32'd1);
      issue(v, r, w, f3, 5'($urandom_range(0, 31)), a, $urandom,
            1'($urandom_range(0, 1)), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom);
    end
    valid_in     = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    tick();

    rst = 1'b1;
    tick();
    rst             = 1'b0;
    valid_in        = 1'b1;
    mem_read_in     = 1'b1;
    funct3_in       = 3'b010;
    rd_in           = 32'h400;
    rd_addr_in      = 5'd9;
    writeback_en_in = 1'b1;
    #1;
    chk("tmo_idle_stall", t_stall, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("tmo_req", t_if.dmem_req, 1);
      chk("tmo_stall", t_stall, 1);
      tick();
    end
    chk("tmo_req_drop", t_if.dmem_req, 0);
    chk("tmo_valid", t_valid, 1);
    chk("tmo_fault", t_fault, 1);
    chk("tmo_wb", t_wb, 0);
    chk("tmo_done_stall", t_stall, 0);
    valid_in    = 1'b0;
    mem_read_in = 1'b0;
    tick();
    chk("tmo_fault_end", t_fault, 0);
    chk("tmo_bubble", t_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    valid_in        = 1'b1;
    mem_read_in     = 1'b1;
    funct3_in       = 3'b101;
    rd_in           = 32'h302;
    rd_addr_in      = 5'd13;
    writeback_en_in = 1'b1;
    #1;
    chk("rr_idle_stall", stall, 1);
    tick();
    m_if.dmem_gnt = 1'b1;
    #1;
    chk("rr_req", m_if.dmem_req, 1);
    tick();
    m_if.dmem_gnt = 1'b0;
    valid_in      = 1'b0;
    mem_read_in   = 1'b0;
    #1;
    chk("rr_resp_stall", stall, 1);
    rst = 1'b1;
    #1;
    chk("rr_req_low", m_if.dmem_req, 0);
    chk("rr_stall_low", stall, 0);
    chk("rr_valid_low", valid_out, 0);
    tick();
    rst = 1'b0;
    m_if.dmem_rvalid = 1'b1;
    m_if.dmem_rdata  = 32'h1234_5678;
    tick();
    m_if.dmem_rvalid = 1'b0;
    chk("rr_stray_valid", valid_out, 0);
    chk("rr_stray_req", m_if.dmem_req, 0);
    tick();
    chk("rr_stray_valid2", valid_out, 0);
    issue(1, 0, 0, 3'b000, 5'd14, 32'hCAFE_F00D, 32'h0, 1, 0, 0, 32'h0);
    valid_in = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
